rgb_pwm_array: RTL and testbench
================================

Name: rgb_pwm_array

Overview:
Parametrised multi-channel RGB PWM driver. It is the successor to the single-LED rgb_controller.
- Drives N_CH RGB LEDs from one free-running PWM timebase.
- Each channel has shadow/active duty registers and a per-channel mode: off, static, blink or breathe.
- Sits between the switch/register front-end and the board RGB pins, alongside seven_segment.

Parameters:
N_CH, 2, number of RGB channels (1..8)
PWM_W, 8, duty and PWM counter width in bits
PRESCALE, 4, clock cycles per PWM count (>=1)
BLINK_PER, 64, PWM periods per blink half-phase (>=1)
STEP_PER, 2, PWM periods per breathe level step (>=1)

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
wr_en  in  1  write strobe for one channel's shadow registers
wr_ch  in  3  target channel index
wr_mode  in  2  mode: 00 OFF, 01 STATIC, 10 BLINK, 11 BREATHE
wr_r  in  PWM_W  red duty
wr_g  in  PWM_W  green duty
wr_b  in  PWM_W  blue duty
wr_ack  out  1  one-cycle pulse, write accepted
wr_err  out  1  one-cycle pulse, wr_ch >= N_CH (write dropped)
period_end  out  1  one-cycle pulse on the last PWM count of each period
r_out  out  N_CH  red PWM per channel
g_out  out  N_CH  green PWM per channel
b_out  out  N_CH  blue PWM per channel

Behaviour:
- Reset (RST high at a CLK edge) clears the following to 0:
  - all counters, shadow and active registers, and modes (mode = OFF);
  - breathe level, with breathe direction set to up and blink phase set to on;
  - all outputs, including wr_ack, wr_err and period_end.
- Reset mid-period aborts the period; the first period after reset starts at count 0.
- Prescaler pre_cnt counts 0..PRESCALE-1. tick = (pre_cnt == PRESCALE-1).
- pwm_cnt (PWM_W bits) increments on tick and wraps from 2^PWM_W-1 to 0.
- period_end = tick && pwm_cnt == 2^PWM_W-1. It is registered and asserts in the cycle after the wrapping tick edge.
- Writes:
  - wr_en with wr_ch < N_CH loads the channel's shadow {mode, r, g, b} at the edge; wr_ack pulses the next cycle.
  - wr_en with wr_ch >= N_CH changes no state; wr_err pulses the next cycle.
- Shadow-to-active copy happens for all channels on the period_end edge, so duty changes are glitch-free at period boundaries.
- Write and copy on the same edge: the pre-write shadow is copied; the new write reaches active at the following period_end.
- Blink phase toggles every BLINK_PER periods (global counter, shared by all channels).
- Breathe level L (PWM_W bits) steps every STEP_PER periods:
  - steps +1 while direction is up; at 2^PWM_W-1 it flips to down;
  - steps -1 while direction is down; at 0 it flips to up;
  - the endpoint value is held for exactly one step interval.
- Effective duty d per colour:
  - OFF: 0.
  - STATIC: active duty.
  - BLINK: active duty in the on phase, 0 in the off phase.
  - BREATHE: (duty * L) >> PWM_W, using a 2*PWM_W-bit product, truncated and unsigned.
- Output: out = (pwm_cnt < d), registered, so one cycle of latency after pwm_cnt changes.
  - d = 0 gives constant low.
  - d = 2^PWM_W-1 gives high for 2^PWM_W-1 of 2^PWM_W counts. Full-on is never reachable, by design.
- Channels are independent. Writes to one channel never disturb another channel's outputs.

Decomposition:
- Package rgb_pwm_pkg:
  - mode encodings: MODE_OFF, MODE_STATIC, MODE_BLINK, MODE_BREATHE;
  - mode width constant MODE_W = 2.
- Sub-module rgb_pwm_channel, instantiated N_CH times. It holds:
  - the shadow and active registers;
  - the effective-duty mux with the breathe multiply;
  - the three output comparators.
- Top level holds the prescaler, pwm_cnt, period_end, blink phase, breathe level, and write decode/ack/err.

Test Plan:
Tests use PWM_W=4, PRESCALE=1, N_CH=2 unless stated. Period length is 16 cycles.
- Reset check: hold RST 3 cycles -> all outputs 0 and period_end first pulses exactly 16 cycles after RST falls; assert RST mid-period -> outputs 0 next cycle and pwm_cnt restarts at 0.
- STATIC duty: write ch0 STATIC r=5, g=0, b=15 -> wr_ack pulse; from the next period, r high 5/16, g never high, b high 15/16 per period; ch1 outputs stay 0.
- Shadow timing: write ch1 r=8 on the same edge as the copy (period_end) -> old value persists one more period, then r high 8/16; wr_ch=3 -> wr_err pulse and no state change.
- BLINK with BLINK_PER=2: ch0 BLINK r=10 -> r is 10/16 for 2 periods, then 0 for 2 periods, repeating.
- BREATHE with STEP_PER=1, r=15: per-period high count follows (15*L)>>4 as L ramps 0,1..15,14..0; check the monotonic rise, peak value 14, and turnaround at both ends.
- Randomised check: random writes at PWM_W=8, PRESCALE=3 against a reference model; outputs must be bit-exact every cycle.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the multi-channel RGB PWM driver.
// Mode encodings used by the write bus and every channel.
package rgb_pwm_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

endpackage

// File: rtl/rgb_pwm_array_if.sv
// Channel write bus: one-shot register write with ack/err pulses.
// The front-end is master, the PWM array is slave.
interface rgb_pwm_array_if #(
    parameter int PWM_W = 8
);
    import rgb_pwm_pkg::*;

    logic             wr_en;
    logic [2:0]       wr_ch;
    mode_e            wr_mode;
    logic [PWM_W-1:0] wr_r;
    logic [PWM_W-1:0] wr_g;
    logic [PWM_W-1:0] wr_b;
    logic             wr_ack;
    logic             wr_err;

    modport master (
        output wr_en, wr_ch, wr_mode, wr_r, wr_g, wr_b,
        input  wr_ack, wr_err
    );

    modport slave (
        input  wr_en, wr_ch, wr_mode, wr_r, wr_g, wr_b,
        output wr_ack, wr_err
    );

endinterface

// File: rtl/rgb_pwm_channel.sv
// One RGB channel: shadow/active registers, effective-duty mux
// and the three registered PWM comparators.
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ld,
    input  mode_e            ld_mode,
    input  logic [PWM_W-1:0] ld_r,
    input  logic [PWM_W-1:0] ld_g,
    input  logic [PWM_W-1:0] ld_b,
    input  logic             copy,
    input  logic             blink_on,
    input  logic [PWM_W-1:0] level,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             r_out,
    output logic             g_out,
    output logic             b_out
);

    mode_e                       sh_mode;
    mode_e                       ac_mode;
    logic [2:0][PWM_W-1:0]       sh_duty;
    logic [2:0][PWM_W-1:0]       ac_duty;
    logic [2:0][PWM_W-1:0]       duty;
    logic [2:0][2*PWM_W-1:0]     prod;

    // Nonblocking copy takes the pre-write shadow when both hit one edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sh_mode <= MODE_OFF;
            ac_mode <= MODE_OFF;
            sh_duty <= '0;
            ac_duty <= '0;
        end else begin
            if (copy) begin
                ac_mode <= sh_mode;
                ac_duty <= sh_duty;
            end
            if (ld) begin
                sh_mode <= ld_mode;
                sh_duty <= {ld_b, ld_g, ld_r};
            end
        end
    end

    always_comb begin
        duty = '0;
        prod = '0;
        for (int c = 0; c < 3; c++) begin
            prod[c] = (2*PWM_W)'(ac_duty[c]) * (2*PWM_W)'(level);
            unique case (ac_mode)
                MODE_OFF:     duty[c] = '0;
                MODE_STATIC:  duty[c] = ac_duty[c];
                MODE_BLINK:   duty[c] = blink_on ? ac_duty[c] : '0;
                MODE_BREATHE: duty[c] = prod[c][2*PWM_W-1:PWM_W];
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out <= 1'b0;
            g_out <= 1'b0;
            b_out <= 1'b0;
        end else begin
            r_out <= pwm_cnt < duty[0];
            g_out <= pwm_cnt < duty[1];
            b_out <= pwm_cnt < duty[2];
        end
    end

endmodule

// File: rtl/rgb_pwm_array.sv
// N_CH RGB PWM driver: shared timebase, blink phase, breathe
// level and write decode; per-channel logic lives in rgb_pwm_channel.
module rgb_pwm_array
    import rgb_pwm_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int PWM_W     = 8,
    parameter int PRESCALE  = 4,
    parameter int BLINK_PER = 64,
    parameter int STEP_PER  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    rgb_pwm_array_if.slave    wr,
    output logic              period_end,
    output logic [N_CH-1:0]   r_out,
    output logic [N_CH-1:0]   g_out,
    output logic [N_CH-1:0]   b_out
);

    localparam int PRE_W = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
    localparam int BLK_W = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
    localparam int STP_W = (STEP_PER  > 1) ? $clog2(STEP_PER)  : 1;
    localparam logic [3:0] NCH4 = 4'(N_CH);

    logic [PRE_W-1:0] pre_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic [STP_W-1:0] step_cnt;
    logic [PWM_W-1:0] level;
    logic             dir_up;
    logic             blink_on;
    logic             tick;
    logic             wrap;
    logic             ch_ok;
    logic [N_CH-1:0]  ld;

    assign tick  = pre_cnt == PRE_W'(PRESCALE - 1);
    assign wrap  = tick && (&pwm_cnt);
    assign ch_ok = {1'b0, wr.wr_ch} < NCH4;

    always_comb begin
        ld = '0;
        for (int c = 0; c < N_CH; c++)
            ld[c] = wr.wr_en && (wr.wr_ch == 3'(c));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_cnt    <= '0;
            pwm_cnt    <= '0;
            period_end <= 1'b0;
            wr.wr_ack  <= 1'b0;
            wr.wr_err  <= 1'b0;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
            step_cnt   <= '0;
            level      <= '0;
            dir_up     <= 1'b1;
        end else begin
            pre_cnt    <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick)
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            period_end <= wrap;
            wr.wr_ack  <= wr.wr_en && ch_ok;
            wr.wr_err  <= wr.wr_en && !ch_ok;
            // Blink and breathe advance at the same edge as the duty copy.
            if (wrap) begin
                if (blink_cnt == BLK_W'(BLINK_PER - 1)) begin
                    blink_cnt <= '0;
                    blink_on  <= !blink_on;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
                if (step_cnt == STP_W'(STEP_PER - 1)) begin
                    step_cnt <= '0;
                    if (dir_up) begin
                        if (&level) begin
                            dir_up <= 1'b0;
                            level  <= level - PWM_W'(1);
                        end else begin
                            level  <= level + PWM_W'(1);
                        end
                    end else begin
                        if (level == '0) begin
                            dir_up <= 1'b1;
                            level  <= level + PWM_W'(1);
                        end else begin
                            level  <= level - PWM_W'(1);
                        end
                    end
                end else begin
                    step_cnt <= step_cnt + STP_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        rgb_pwm_channel #(
            .PWM_W (PWM_W)
        ) u_ch (
            .CLK      (CLK),
            .RST      (RST),
            .ld       (ld[g]),
            .ld_mode  (wr.wr_mode),
            .ld_r     (wr.wr_r),
            .ld_g     (wr.wr_g),
            .ld_b     (wr.wr_b),
            .copy     (wrap),
            .blink_on (blink_on),
            .level    (level),
            .pwm_cnt  (pwm_cnt),
            .r_out    (r_out[g]),
            .g_out    (g_out[g]),
            .b_out    (b_out[g])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_array.sv
// Bench for rgb_pwm_array: two configurations checked every cycle
// against an arithmetic model derived from elapsed clock count.
module tb_rgb_pwm_array;
    import rgb_pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rsta = 1'b1;
    logic       rstb = 1'b1;
    logic       pea, peb;
    logic [1:0] ra, ga, ba;
    logic [2:0] rb, gb, bb;

    int checks = 0;
    int errors = 0;

    int k [2];
    int sh[2][8][4];
    int ac[2][8][4];

    always #5 clk = ~clk;

    rgb_pwm_array_if #(.PWM_W(4)) ifa ();
    rgb_pwm_array_if #(.PWM_W(8)) ifb ();

    rgb_pwm_array #(
        .N_CH(2), .PWM_W(4), .PRESCALE(1), .BLINK_PER(2), .STEP_PER(1)
    ) dut_a (
        .CLK(clk), .RST(rsta), .wr(ifa.slave), .period_end(pea),
        .r_out(ra), .g_out(ga), .b_out(ba)
    );

    rgb_pwm_array #(
        .N_CH(3), .PWM_W(8), .PRESCALE(3), .BLINK_PER(3), .STEP_PER(2)
    ) dut_b (
        .CLK(clk), .RST(rstb), .wr(ifb.slave), .period_end(peb),
        .r_out(rb), .g_out(gb), .b_out(bb)
    );

    // Triangle level: 0..MAX..1 repeating, one value per step interval.
    function automatic int duty_eff(int mode, int duty, int p,
                                    int w, int bp, int sp);
        int mx = (1 << w) - 1;
        int t  = (p / sp) % (2 * mx);
        int lv = (t <= mx) ? t : 2 * mx - t;
        case (mode)
            1:       return duty;
            2:       return ((p / bp) % 2 == 0) ? duty : 0;
            3:       return (duty * lv) >> w;
            default: return 0;
        endcase
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(int i, bit rst, bit en, int ch, int mode,
                        int r, int g, int b);
        int w, ps, n, bp, sp, prd, t0, t1, cnt, p;
        logic [7:0] er, eg, eb;
        bit ewrap, eack, eerr;
        w   = (i == 0) ? 4 : 8;
        ps  = (i == 0) ? 1 : 3;
        n   = (i == 0) ? 2 : 3;
        bp  = (i == 0) ? 2 : 3;
        sp  = (i == 0) ? 1 : 2;
        prd = 1 << w;
        if (i == 0) begin
            rsta = rst; ifa.wr_en = en; ifa.wr_ch = 3'(ch);
            ifa.wr_mode = mode_e'(mode);
            ifa.wr_r = 4'(r); ifa.wr_g = 4'(g); ifa.wr_b = 4'(b);
        end else begin
            rstb = rst; ifb.wr_en = en; ifb.wr_ch = 3'(ch);
            ifb.wr_mode = mode_e'(mode);
            ifb.wr_r = 8'(r); ifb.wr_g = 8'(g); ifb.wr_b = 8'(b);
        end
        t0  = k[i] / ps;
        cnt = t0 % prd;
        p   = t0 / prd;
        er = '0; eg = '0; eb = '0;
        if (!rst) begin
            for (int c = 0; c < n; c++) begin
                er[c] = cnt < duty_eff(ac[i][c][0], ac[i][c][1], p, w, bp, sp);
                eg[c] = cnt < duty_eff(ac[i][c][0], ac[i][c][2], p, w, bp, sp);
                eb[c] = cnt < duty_eff(ac[i][c][0], ac[i][c][3], p, w, bp, sp);
            end
        end
        t1    = (k[i] + 1) / ps;
        ewrap = !rst && (t1 != t0) && (t1 % prd == 0);
        eack  = !rst && en && (ch < n);
        eerr  = !rst && en && (ch >= n);
        @(posedge clk);
        #1;
        if (rst) begin
            k[i] = 0;
            for (int c = 0; c < 8; c++)
                for (int f = 0; f < 4; f++) begin
                    sh[i][c][f] = 0;
                    ac[i][c][f] = 0;
                end
        end else begin
            if (ewrap)
                for (int c = 0; c < 8; c++)
                    for (int f = 0; f < 4; f++)
                        ac[i][c][f] = sh[i][c][f];
            if (eack) begin
                sh[i][ch][0] = mode; sh[i][ch][1] = r;
                sh[i][ch][2] = g;    sh[i][ch][3] = b;
            end
            k[i]++;
        end
        if (i == 0) begin
            chk("a_ack", 8'(ifa.wr_ack), 8'(eack));
            chk("a_err", 8'(ifa.wr_err), 8'(eerr));
            chk("a_pe",  8'(pea), 8'(ewrap));
            chk("a_r",   8'(ra), er);
            chk("a_g",   8'(ga), eg);
            chk("a_b",   8'(ba), eb);
        end else begin
            chk("b_ack", 8'(ifb.wr_ack), 8'(eack));
            chk("b_err", 8'(ifb.wr_err), 8'(eerr));
            chk("b_pe",  8'(peb), 8'(ewrap));
            chk("b_r",   8'(rb), er);
            chk("b_g",   8'(gb), eg);
            chk("b_b",   8'(bb), eb);
        end
    endtask

    task automatic idle(int i, int n);
        repeat (n) step(i, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int hr, hg, hb;
        ifb.wr_en = 1'b0; ifb.wr_ch = '0; ifb.wr_mode = MODE_OFF;
        ifb.wr_r = '0; ifb.wr_g = '0; ifb.wr_b = '0;
        k[0] = 0; k[1] = 0;

        repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 20);

        step(0, 0, 1, 0, 1, 5, 0, 15);
        idle(0, 40);
        hr = 0; hg = 0; hb = 0;
        for (int j = 0; j < 16; j++) begin
            idle(0, 1);
            hr += int'(ra[0]); hg += int'(ga[0]); hb += int'(ba[0]);
        end
        chk("static_r_hi", 8'(hr), 8'd5);
        chk("static_g_hi", 8'(hg), 8'd0);
        chk("static_b_hi", 8'(hb), 8'd15);

        while (k[0] % 16 != 15) idle(0, 1);
        step(0, 0, 1, 1, 1, 8, 0, 0);
        idle(0, 40);
        step(0, 0, 1, 3, 1, 9, 9, 9);
        idle(0, 5);

        step(0, 0, 1, 0, 2, 10, 0, 0);
        idle(0, 40);
        hr = 0;
        for (int j = 0; j < 64; j++) begin
            idle(0, 1);
            hr += int'(ra[0]);
        end
        chk("blink_r_hi", 8'(hr), 8'd20);

        step(0, 0, 1, 0, 3, 15, 7, 1);
        idle(0, 520);

        while (k[0] % 16 != 7) idle(0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 20);

        for (int j = 0; j < 300; j++) begin
            if ($urandom_range(7) == 0)
                step(0, 0, 1, int'($urandom_range(3)), int'($urandom_range(3)),
                     int'($urandom_range(15)), int'($urandom_range(15)),
                     int'($urandom_range(15)));
            else
                idle(0, 1);
        end

        repeat (2) step(1, 1, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 20000; j++) begin
            if ($urandom_range(63) == 0)
                step(1, 0, 1, int'($urandom_range(7)), int'($urandom_range(3)),
                     int'($urandom_range(255)), int'($urandom_range(255)),
                     int'($urandom_range(255)));
            else
                idle(1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
